// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default
// frame geometry and a constant-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Number of bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// chosen by the instantiating block so an idle-high line stays idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled. The rising edge of 'baud' is one sample tick;
// each good byte is presented on data_out with a one-clock 'received' strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 received,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_nx;
    logic                 r_baud_q;
    logic                 w_tick;
    logic                 w_rx_s;
    logic [TW-1:0]        r_tick_cnt;
    logic [TW-1:0]        w_tick_cnt_nx;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt_nx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_nx;
    logic [DATA_BITS-1:0] r_data_out;
    logic [DATA_BITS-1:0] w_data_nx;
    logic                 r_received;
    logic                 w_recv_nx;
    logic                 r_frame_err;
    logic                 w_ferr_nx;
    logic                 r_busy;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_tick = baud & ~r_baud_q;

    // Next-state, counter, shift-register and strobe logic; nothing moves without a tick except BREAK exit.
    always_comb begin
        w_state_nx    = r_state;
        w_tick_cnt_nx = r_tick_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shreg_nx    = r_shreg;
        w_data_nx     = r_data_out;
        w_recv_nx     = 1'b0;
        w_ferr_nx     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rx_s) begin
                    w_state_nx    = ST_START;
                    w_tick_cnt_nx = {TW{1'b0}};
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        if (!w_rx_s) begin
                            w_state_nx    = ST_DATA;
                            w_tick_cnt_nx = {TW{1'b0}};
                            w_bit_cnt_nx  = {BW{1'b0}};
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_tick_cnt_nx = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_state_nx = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        // LSB arrives first, so shift in from the top.
                        w_shreg_nx    = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        w_tick_cnt_nx = {TW{1'b0}};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nx = ST_STOP;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + BW'(1);
                        end
                    end else begin
                        w_tick_cnt_nx = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_state_nx = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_nx = {TW{1'b0}};
                        if (w_rx_s) begin
                            w_data_nx  = r_shreg;
                            w_recv_nx  = 1'b1;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_ferr_nx  = 1'b1;
                            w_state_nx = ST_BREAK;
                        end
                    end else begin
                        w_tick_cnt_nx = r_tick_cnt + TW'(1);
                    end
                end else begin
                    w_state_nx = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A held-low line must go high before a new start edge counts.
                if (w_rx_s) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_BREAK;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_baud_q    <= 1'b0;
            r_tick_cnt  <= {TW{1'b0}};
            r_bit_cnt   <= {BW{1'b0}};
            r_shreg     <= {DATA_BITS{1'b0}};
            r_data_out  <= {DATA_BITS{1'b0}};
            r_received  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_baud_q    <= baud;
            r_tick_cnt  <= w_tick_cnt_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_shreg     <= w_shreg_nx;
            r_data_out  <= w_data_nx;
            r_received  <= w_recv_nx;
            r_frame_err <= w_ferr_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

    assign data_out  = r_data_out;
    assign received  = r_received;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. 'baud' is a fast square wave (one tick every
// 4 clk) so a full frame takes 640 clk; line timing is counted in ticks.
module tb_uart_rx;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       baud    = 1'b0;
    logic       rx      = 1'b1;
    logic       baud_en = 1'b1;
    logic [7:0] data_out;
    logic       received;
    logic       frame_err;
    logic       busy;

    int         checks      = 0;
    int         errors      = 0;
    int         rcv_cnt     = 0;
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    int         long_cnt    = 0;
    logic       prev_recv   = 1'b0;
    logic       prev_ferr   = 1'b0;
    logic [7:0] got_q[$];

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .baud      (baud),
        .rx        (rx),
        .data_out  (data_out),
        .received  (received),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Baud square wave; edges land on falling clk edges. Freezes while baud_en is low.
    always begin
        #20;
        if (baud_en) baud = ~baud;
    end

    // Strobe monitor: captures every good byte and tracks pulse-shape violations.
    always @(negedge clk) begin
        if (received) begin
            got_q.push_back(data_out);
            rcv_cnt <= rcv_cnt + 1;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (received && frame_err) overlap_cnt <= overlap_cnt + 1;
        if ((received && prev_recv) || (frame_err && prev_ferr)) long_cnt <= long_cnt + 1;
        prev_recv <= received;
        prev_ferr <= frame_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge baud);
    endtask

    task automatic send_bits(input logic [7:0] d);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(d);
        rx = 1'b1;
        wait_ticks(16);
    endtask

    task automatic check_next_byte(input string tag, input logic [7:0] exp);
        if (got_q.size() == 0) begin
            check({tag, "_missing"}, 32'(got_q.size()), 32'd1);
        end else begin
            check(tag, 32'(got_q.pop_front()), 32'(exp));
        end
    endtask

    initial begin
        int s_rcv;
        int s_ferr;
        int busy_low;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_received", 32'(received), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wait_ticks(4);

        // 1: single 0x55
        send_byte(8'h55);
        wait_ticks(4);
        check("t1_rcv_cnt", 32'(rcv_cnt), 32'd1);
        check_next_byte("t1_byte", 8'h55);
        check("t1_data_out", 32'(data_out), 32'h55);
        check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // 2: back-to-back frames with no idle gap
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_byte(8'h34);
        wait_ticks(4);
        check("t2_rcv_cnt", 32'(rcv_cnt), 32'd5);
        check_next_byte("t2_byte0", 8'h00);
        check_next_byte("t2_byte1", 8'hFF);
        check_next_byte("t2_byte2", 8'h12);
        check_next_byte("t2_byte3", 8'h34);
        check("t2_data_out", 32'(data_out), 32'h34);

        // 3: 3-tick glitch in IDLE
        rx = 1'b0;
        wait_ticks(2);
        check("t3_busy_in_glitch", 32'(busy), 32'h1);
        wait_ticks(1);
        rx = 1'b1;
        wait_ticks(12);
        check("t3_busy_after", 32'(busy), 32'h0);
        check("t3_rcv_cnt", 32'(rcv_cnt), 32'd5);
        check("t3_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // 4: stop bit low, line held low, then recovery
        send_bits(8'hA5);
        rx = 1'b0;
        wait_ticks(40);
        check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("t4_rcv_cnt", 32'(rcv_cnt), 32'd5);
        check("t4_data_kept", 32'(data_out), 32'h34);
        check("t4_busy_break", 32'(busy), 32'h1);
        wait_ticks(8);
        rx = 1'b1;
        wait_ticks(2);
        check("t4_busy_idle", 32'(busy), 32'h0);
        send_byte(8'h3C);
        wait_ticks(4);
        check_next_byte("t4_byte", 8'h3C);
        check("t4_data_out", 32'(data_out), 32'h3C);

        // 5: reset in the middle of bit 4 of 0x99
        s_rcv = rcv_cnt;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h99 >> i);
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_data_out", 32'(data_out), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_received", 32'(received), 32'h0);
        wait_ticks(40);
        check("t5_no_pulse", 32'(rcv_cnt), 32'(s_rcv));
        send_byte(8'h99);
        wait_ticks(4);
        check_next_byte("t5_byte", 8'h99);

        // 6: baud stalled mid-frame
        s_rcv  = rcv_cnt;
        s_ferr = ferr_cnt;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h6B >> i);
            wait_ticks(16);
        end
        rx = 1'(8'h6B >> 3);
        wait_ticks(5);
        baud_en = 1'b0;
        busy_low = 0;
        repeat (5000) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        check("t6_busy_stall", 32'(busy_low), 32'd0);
        check("t6_rcv_stall", 32'(rcv_cnt), 32'(s_rcv));
        check("t6_ferr_stall", 32'(ferr_cnt), 32'(s_ferr));
        baud_en = 1'b1;
        wait_ticks(11);
        for (int i = 4; i < 8; i++) begin
            rx = 1'(8'h6B >> i);
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(20);
        check_next_byte("t6_byte", 8'h6B);
        check("t6_data_out", 32'(data_out), 32'h6B);

        // Whole-run strobe properties
        check("total_rcv_cnt", 32'(rcv_cnt), 32'd8);
        check("total_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check("strobe_width", 32'(long_cnt), 32'd0);
        check("leftover_bytes", 32'(got_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
